// File: rtl/round_scorer.sv
// Tug-of-war round/match scorer: detects edge wins, keeps scores, drives the
// resetRound recentre line and the active-low 7-segment score digits.
module round_scorer #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       leftEdge,
  input  logic       rightEdge,
  output logic       resetRound,
  output logic [2:0] leftScore,
  output logic [2:0] rightScore,
  output logic [6:0] hexL,
  output logic [6:0] hexR,
  output logic       gameOver,
  output logic       winner
);

  typedef enum logic [1:0] {PLAY, HOLD, GAME_OVER} state_t;

  localparam logic [2:0] WIN_S      = 3'(WIN_SCORE);
  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [2:0] left_q, left_d, right_q, right_d;
  logic       rr_q, rr_d;
  logic       go_q, go_d;
  logic       win_q, win_d;

  logic       left_win, right_win;
  logic [2:0] left_inc, right_inc;

  assign left_win  = leftEdge & L & ~R;
  assign right_win = rightEdge & R & ~L;
  assign left_inc  = left_q + 3'd1;
  assign right_inc = right_q + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLAY;
      hold_q  <= 4'd0;
      left_q  <= 3'd0;
      right_q <= 3'd0;
      rr_q    <= 1'b0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      left_q  <= left_d;
      right_q <= right_d;
      rr_q    <= rr_d;
      go_q    <= go_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    left_d  = left_q;
    right_d = right_q;
    rr_d    = rr_q;
    go_d    = go_q;
    win_d   = win_q;
    unique case (state_q)
      PLAY: begin
        if (left_win || right_win) begin
          rr_d = 1'b1;
          if (left_win) left_d = left_inc;
          else          right_d = right_inc;
          if ((left_win && left_inc == WIN_S) || (right_win && right_inc == WIN_S)) begin
            state_d = GAME_OVER;
            go_d    = 1'b1;
            win_d   = right_win;
          end else begin
            state_d = HOLD;
            hold_d  = HOLD_RELOAD;
          end
        end
      end
      HOLD: begin
        // Counter reaching zero ends the hold so resetRound spans HOLD_CYCLES cycles.
        if (hold_q == 4'd0) begin
          state_d = PLAY;
          rr_d    = 1'b0;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      GAME_OVER: begin
        rr_d = 1'b1;
      end
      default: begin
        state_d = PLAY;
        rr_d    = 1'b0;
      end
    endcase
  end

  function automatic logic [6:0] seg7(input logic [2:0] v);
    unique case (v)
      3'd0:    seg7 = 7'b1000000;
      3'd1:    seg7 = 7'b1111001;
      3'd2:    seg7 = 7'b0100100;
      3'd3:    seg7 = 7'b0110000;
      3'd4:    seg7 = 7'b0011001;
      3'd5:    seg7 = 7'b0010010;
      3'd6:    seg7 = 7'b0000010;
      default: seg7 = 7'b1111000;
    endcase
  endfunction

  assign resetRound = rr_q;
  assign leftScore  = left_q;
  assign rightScore = right_q;
  assign gameOver   = go_q;
  assign winner     = win_q;
  assign hexL       = seg7(left_q);
  assign hexR       = seg7(right_q);

endmodule

// File: tb/tb_round_scorer.sv
// Directed bench for round_scorer: default instance plus a WIN_SCORE=1 instance.
module tb_round_scorer;

  logic       clk = 1'b0;
  logic       reset;
  logic       L, R, leftEdge, rightEdge;
  logic       resetRound;
  logic [2:0] leftScore, rightScore;
  logic [6:0] hexL, hexR;
  logic       gameOver, winner;

  logic       L1, R1, leftEdge1, rightEdge1;
  logic       resetRound1;
  logic [2:0] leftScore1, rightScore1;
  logic [6:0] hexL1, hexR1;
  logic       gameOver1, winner1;

  int checks = 0;
  int failures = 0;
  logic [6:0] seg_tab [8];

  always #5 clk = ~clk;

  round_scorer #(.WIN_SCORE(7), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .leftEdge(leftEdge), .rightEdge(rightEdge),
    .resetRound(resetRound), .leftScore(leftScore), .rightScore(rightScore),
    .hexL(hexL), .hexR(hexR), .gameOver(gameOver), .winner(winner)
  );

  round_scorer #(.WIN_SCORE(1), .HOLD_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset), .L(L1), .R(R1), .leftEdge(leftEdge1), .rightEdge(rightEdge1),
    .resetRound(resetRound1), .leftScore(leftScore1), .rightScore(rightScore1),
    .hexL(hexL1), .hexR(hexR1), .gameOver(gameOver1), .winner(winner1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;

    reset = 1'b1;
    L = 0; R = 0; leftEdge = 0; rightEdge = 0;
    L1 = 0; R1 = 0; leftEdge1 = 0; rightEdge1 = 0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_rr",    32'(resetRound), 32'(0));
    chk("rst_left",  32'(leftScore),  32'(0));
    chk("rst_right", 32'(rightScore), 32'(0));
    chk("rst_hexL",  32'(hexL), 32'(7'b1000000));
    chk("rst_hexR",  32'(hexR), 32'(7'b1000000));
    chk("rst_go",    32'(gameOver), 32'(0));
    chk("rst_win",   32'(winner), 32'(0));
    chk("rst_go1",   32'(gameOver1), 32'(0));

    // Left round win, then R+rightEdge during the hold is ignored
    L = 1; leftEdge = 1;
    tick();
    L = 0; leftEdge = 0;
    chk("lwin_score", 32'(leftScore), 32'(1));
    chk("lwin_hexL",  32'(hexL), 32'(7'b1111001));
    chk("lwin_rr",    32'(resetRound), 32'(1));
    R = 1; rightEdge = 1;
    tick();
    R = 0; rightEdge = 0;
    chk("hold_rr2",    32'(resetRound), 32'(1));
    chk("hold_rscore", 32'(rightScore), 32'(0));
    tick();
    chk("hold_rr3", 32'(resetRound), 32'(1));
    tick();
    chk("hold_rr4", 32'(resetRound), 32'(1));
    tick();
    chk("hold_end_rr", 32'(resetRound), 32'(0));
    chk("hold_end_rscore", 32'(rightScore), 32'(0));

    // Simultaneous presses score nothing; press toward unlit edge scores nothing
    L = 1; R = 1; leftEdge = 1;
    tick();
    L = 0; R = 0; leftEdge = 0;
    chk("both_left", 32'(leftScore), 32'(1));
    chk("both_rr",   32'(resetRound), 32'(0));
    R = 1;
    tick();
    R = 0;
    chk("unlit_right", 32'(rightScore), 32'(0));
    chk("unlit_rr",    32'(resetRound), 32'(0));
    rightEdge = 1;
    tick();
    rightEdge = 0;
    chk("nopress_right", 32'(rightScore), 32'(0));

    // Right takes seven rounds and the match
    for (int i = 1; i <= 7; i++) begin
      R = 1; rightEdge = 1;
      tick();
      R = 0; rightEdge = 0;
      chk("rwin_score", 32'(rightScore), 32'(i));
      chk("rwin_hexR",  32'(hexR), 32'(seg_tab[i]));
      chk("rwin_rr",    32'(resetRound), 32'(1));
      if (i < 7) begin
        chk("rwin_go_low", 32'(gameOver), 32'(0));
        tick(); tick(); tick(); tick();
        chk("rwin_hold_done", 32'(resetRound), 32'(0));
      end
    end
    chk("match_go",   32'(gameOver), 32'(1));
    chk("match_win",  32'(winner), 32'(1));
    chk("match_hexR", 32'(hexR), 32'(7'b1111000));
    chk("match_left", 32'(leftScore), 32'(1));
    L = 1; leftEdge = 1;
    tick();
    L = 0; leftEdge = 0;
    tick(); tick(); tick(); tick(); tick();
    chk("over_left",  32'(leftScore), 32'(1));
    chk("over_right", 32'(rightScore), 32'(7));
    chk("over_rr",    32'(resetRound), 32'(1));
    chk("over_go",    32'(gameOver), 32'(1));
    chk("over_win",   32'(winner), 32'(1));

    // Clear the match, then reset on the 2nd cycle of a hold
    reset = 1;
    tick();
    reset = 0;
    chk("rst2_go",    32'(gameOver), 32'(0));
    chk("rst2_rr",    32'(resetRound), 32'(0));
    chk("rst2_right", 32'(rightScore), 32'(0));
    L = 1; leftEdge = 1;
    tick();
    L = 0; leftEdge = 0;
    chk("pre_hold_rr", 32'(resetRound), 32'(1));
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("midhold_rr",   32'(resetRound), 32'(0));
    chk("midhold_left", 32'(leftScore), 32'(0));
    chk("midhold_go",   32'(gameOver), 32'(0));
    tick();
    chk("midhold_rr_stays", 32'(resetRound), 32'(0));
    L = 1; leftEdge = 1;
    tick();
    L = 0; leftEdge = 0;
    chk("after_left", 32'(leftScore), 32'(1));
    chk("after_rr",   32'(resetRound), 32'(1));
    chk("after_hexL", 32'(hexL), 32'(7'b1111001));

    // WIN_SCORE=1: one right win ends the match with no hold
    chk("w1_pre_go", 32'(gameOver1), 32'(0));
    R1 = 1; rightEdge1 = 1;
    tick();
    R1 = 0; rightEdge1 = 0;
    chk("w1_right", 32'(rightScore1), 32'(1));
    chk("w1_go",    32'(gameOver1), 32'(1));
    chk("w1_win",   32'(winner1), 32'(1));
    chk("w1_rr",    32'(resetRound1), 32'(1));
    chk("w1_hexR",  32'(hexR1), 32'(7'b1111001));
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("w1_rr_held", 32'(resetRound1), 32'(1));
    chk("w1_left",    32'(leftScore1), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
